dp_ram: RTL and testbench
=========================

DP_RAM -- requirements
Module: dp_ram

Interface
REQ-001 SHALL have parameter DATA_W, default 8: word width in bits; legal values are multiples of 8.
REQ-002 SHALL have parameter ADDR_W, default 4: address width; DEPTH = 2**ADDR_W words.
REQ-003 SHALL have parameter RD_MODE, default 0: same-address collision policy; 0 = read-first, 1 = write-first.
REQ-004 SHALL have parameter OUT_REG, default 0: 1 adds an output pipeline register.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port we, input, 1 bit: write enable.
REQ-008 SHALL have port waddr, input, ADDR_W bits: write address.
REQ-009 SHALL have port wdata, input, DATA_W bits: write data.
REQ-010 SHALL have port wbe, input, DATA_W/8 bits: byte enables; bit i covers wdata[8i+7:8i].
REQ-011 SHALL have port re, input, 1 bit: read enable.
REQ-012 SHALL have port raddr, input, ADDR_W bits: read address.
REQ-013 SHALL have port rdata, output, DATA_W bits: registered read data.
REQ-014 SHALL have port rvalid, output, 1 bit: one-cycle pulse marking rdata valid for one accepted read.
REQ-015 SHALL have port init_busy, output, 1 bit: high while the memory-clear sweep runs.

Function
REQ-016 SHALL implement a two-state FSM: CLEAR, then RUN.
- CLEAR: each edge with rst=0 writes zero to mem[cnt] and increments cnt.
- The edge that clears DEPTH-1 moves to RUN and drops init_busy.
- init_busy is therefore high for exactly DEPTH cycles after rst falls.
REQ-017 SHALL ignore we and re entirely while in CLEAR: no write, no rvalid.
REQ-018 SHALL, in RUN with we=1, update only the bytes of mem[waddr] whose wbe bit is 1.
REQ-019 SHALL, in RUN, treat we=1 with wbe=0 as a no-op.
REQ-020 SHALL, in RUN with re=1, return mem[raddr] on rdata with rvalid=1.
- Latency is 1 cycle for OUT_REG=0 and 2 cycles for OUT_REG=1.
- Full throughput: one read accepted per cycle.
REQ-021 SHALL hold rdata at its last value when no read completes; rvalid=0 in those cycles.
REQ-022 SHALL resolve a same-cycle read and write to the same address as follows.
- RD_MODE=0: return the pre-write word.
- RD_MODE=1: return the byte-merged post-write word.
REQ-023 SHALL make reads and writes to different addresses in the same cycle fully independent.
REQ-024 SHALL wrap cnt and addresses modulo DEPTH, with no out-of-range access possible.

Reset
REQ-025 SHALL, on any edge with rst=1 (including mid-sweep or mid-read), do all of the following.
- Enter CLEAR with cnt=0 and init_busy=1.
- Set rdata=0 and rvalid=0.
- Flush the OUT_REG pipeline stage.
- Restart the full clear sweep once rst falls.
REQ-026 SHALL NOT require memory contents to be reset directly; they are zeroed only by the sweep.

Structure
REQ-027 SHALL place the FSM state enum (CLEAR, RUN) and the RD_MODE constants (RD_FIRST=0, WR_FIRST=1) in package dp_ram_pkg.
REQ-028 SHALL implement the byte-enable merge as one combinational sub-module, dp_ram_bmerge.
- Inputs: old word, new word, wbe.
- Output: merged word.
- Used by both the write path and the RD_MODE=1 bypass.

Verification (DATA_W=16, ADDR_W=4)
REQ-029 SHALL check that after rst is released init_busy=1 for exactly 16 cycles, then reads of all 16 addresses return 0x0000.
REQ-030 SHALL check: write 0xABCD to addr 3 with wbe=11, then write 0x1200 with wbe=10, then read addr 3 -> rdata=0x12CD; one cycle later with OUT_REG=0, two cycles later with OUT_REG=1.
REQ-031 SHALL check: mem[5]=0x1111, then in the same cycle write 0x2222 (wbe=11) and read addr 5 -> RD_MODE=0 returns 0x1111, RD_MODE=1 returns 0x2222; a following read returns 0x2222.
REQ-032 SHALL check: back-to-back reads of addrs 0..15 with re held high -> 16 consecutive rvalid pulses with data in order; rdata holds the last value after re falls.
REQ-033 SHALL check: rst asserted for 1 cycle at cnt=7 of the sweep and again during a pending OUT_REG=1 read -> rvalid suppressed, rdata=0, and init_busy high for a fresh 16 cycles.
REQ-034 SHALL check: we and re asserted throughout CLEAR -> no rvalid, and all words read 0 after init_busy falls.

Source files
------------

// File: rtl/dp_ram_pkg.sv
// Shared types and constants for the byte-writable RAM with a power-on clear sweep.
package dp_ram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } dp_state_e;

    localparam int RD_FIRST = 0;
    localparam int WR_FIRST = 1;

endpackage

// File: rtl/dp_ram_bmerge.sv
// Byte-lane merge: lanes with a set enable take the new word, others keep the old one.
module dp_ram_bmerge
    import dp_ram_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0]   i_old,
    input  logic [DATA_W-1:0]   i_new,
    input  logic [DATA_W/8-1:0] i_wbe,
    output logic [DATA_W-1:0]   o_merged
);

    localparam int NB = DATA_W / 8;

    // Select each byte lane independently
    always_comb begin
        o_merged = i_old;
        for (int b = 0; b < NB; b++) begin
            if (i_wbe[b]) begin
                o_merged[8*b +: 8] = i_new[8*b +: 8];
            end else begin
                o_merged[8*b +: 8] = i_old[8*b +: 8];
            end
        end
    end

endmodule

// File: rtl/dp_ram.sv
// Simple dual-port RAM with byte enables, selectable collision policy, optional
// output register, and a hardware clear sweep after every reset.
module dp_ram
    import dp_ram_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 4,
    parameter int RD_MODE = 0,
    parameter int OUT_REG = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [ADDR_W-1:0]   waddr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wbe,
    input  logic                re,
    input  logic [ADDR_W-1:0]   raddr,
    output logic [DATA_W-1:0]   rdata,
    output logic                rvalid,
    output logic                init_busy
);

    localparam int                DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    dp_state_e         r_state;
    dp_state_e         w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_nxt;
    logic              r_init_busy;
    logic              w_init_busy_nxt;

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_run;
    logic              w_wr_en;
    logic              w_rd_en;
    logic              w_collide;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;
    logic [DATA_W-1:0] w_wr_old;
    logic [DATA_W-1:0] w_wr_merged;
    logic [DATA_W-1:0] w_rd_word;
    logic [DATA_W-1:0] r_rdata;
    logic              r_rvalid;

    assign w_run = (r_state == RUN);

    // State, sweep counter and busy flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= CLEAR;
            r_cnt       <= '0;
            r_init_busy <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_init_busy <= w_init_busy_nxt;
        end
    end

    // Next-state logic: sweep every address once, then stay in RUN until reset
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_init_busy_nxt = r_init_busy;
        case (r_state)
            CLEAR: begin
                w_cnt_nxt = r_cnt + ADDR_W'(1);
                if (r_cnt == LAST_ADDR) begin
                    w_state_nxt     = RUN;
                    w_init_busy_nxt = 1'b0;
                end else begin
                    w_state_nxt     = CLEAR;
                    w_init_busy_nxt = 1'b1;
                end
            end
            RUN: begin
                w_state_nxt     = RUN;
                w_cnt_nxt       = r_cnt;
                w_init_busy_nxt = 1'b0;
            end
            default: begin
                w_state_nxt     = CLEAR;
                w_cnt_nxt       = '0;
                w_init_busy_nxt = 1'b1;
            end
        endcase
    end

    // One merge serves the write path and, on a same-address hit, the write-first bypass
    assign w_wr_old = r_mem[waddr];

    dp_ram_bmerge #(
        .DATA_W (DATA_W)
    ) u_bmerge (
        .i_old    (w_wr_old),
        .i_new    (wdata),
        .i_wbe    (wbe),
        .o_merged (w_wr_merged)
    );

    // Write port mux: the sweep owns the port during CLEAR, user writes only in RUN
    always_comb begin
        if (!w_run) begin
            w_wr_en     = ~rst;
            w_mem_addr  = r_cnt;
            w_mem_wdata = '0;
        end else begin
            w_wr_en     = ~rst & we & (|wbe);
            w_mem_addr  = waddr;
            w_mem_wdata = w_wr_merged;
        end
    end

    // Storage array; contents are zeroed only by the sweep
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    assign w_collide = w_run & we & (waddr == raddr);
    assign w_rd_en   = w_run & re & ~rst;

    // Read word selection for the configured collision policy
    always_comb begin
        if ((RD_MODE == WR_FIRST) && w_collide) begin
            w_rd_word = w_wr_merged;
        end else begin
            w_rd_word = r_mem[raddr];
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic              r_pipe_valid;
            logic [DATA_W-1:0] r_pipe_data;

            // Two-stage read pipeline; reset flushes any read in flight
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_pipe_valid <= 1'b0;
                    r_pipe_data  <= '0;
                    r_rvalid     <= 1'b0;
                    r_rdata      <= '0;
                end else begin
                    r_pipe_valid <= w_rd_en;
                    if (w_rd_en) begin
                        r_pipe_data <= w_rd_word;
                    end
                    r_rvalid <= r_pipe_valid;
                    if (r_pipe_valid) begin
                        r_rdata <= r_pipe_data;
                    end
                end
            end
        end else begin : g_out_direct
            // Single-stage read register; rdata holds between reads
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_rvalid <= 1'b0;
                    r_rdata  <= '0;
                end else begin
                    r_rvalid <= w_rd_en;
                    if (w_rd_en) begin
                        r_rdata <= w_rd_word;
                    end
                end
            end
        end
    endgenerate

    assign rdata     = r_rdata;
    assign rvalid    = r_rvalid;
    assign init_busy = r_init_busy;

endmodule

// File: tb/tb_dp_ram.sv
// Scoreboard bench: four dp_ram instances (both collision policies x both latencies)
// share one directed stimulus stream; per-instance monitors pop expected reads.
module tb_dp_ram;

    localparam int DW   = 16;
    localparam int AW   = 4;
    localparam int NCFG = 4;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
        string         name;
    } exp_t;

    logic                      clk   = 1'b0;
    logic                      rst   = 1'b1;
    logic                      we    = 1'b0;
    logic                      re    = 1'b0;
    logic [AW-1:0]             waddr = '0;
    logic [AW-1:0]             raddr = '0;
    logic [DW-1:0]             wdata = '0;
    logic [DW/8-1:0]           wbe   = '0;
    logic [NCFG-1:0][DW-1:0]   rdata_v;
    logic [NCFG-1:0]           rvalid_v;
    logic [NCFG-1:0]           busy_v;

    exp_t exp_q[NCFG][$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // cfg index g: RD_MODE = g%2, OUT_REG = g/2
    for (genvar g = 0; g < NCFG; g++) begin : g_dut
        dp_ram #(
            .DATA_W  (DW),
            .ADDR_W  (AW),
            .RD_MODE (g % 2),
            .OUT_REG (g / 2)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .we        (we),
            .waddr     (waddr),
            .wdata     (wdata),
            .wbe       (wbe),
            .re        (re),
            .raddr     (raddr),
            .rdata     (rdata_v[g]),
            .rvalid    (rvalid_v[g]),
            .init_busy (busy_v[g])
        );

        always @(negedge clk) begin : mon
            exp_t e;
            if (rvalid_v[g] === 1'b1) begin
                tests++;
                if (exp_q[g].size() == 0) begin
                    fails++;
                    $display("FAIL cfg%0d unexpected_rvalid: got rvalid=1 rdata=%h at cycle %0d, required rvalid=0",
                             g, rdata_v[g], cyc);
                end else begin
                    e = exp_q[g].pop_front();
                    if (rdata_v[g] !== e.data || cyc != e.due) begin
                        fails++;
                        $display("FAIL cfg%0d %s: got rdata=%h at cycle %0d, required rdata=%h at cycle %0d",
                                 g, e.name, rdata_v[g], cyc, e.data, e.due);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] req);
        tests++;
        if (got !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", nm, got, req);
        end
    endtask

    // One cycle of stimulus; a read pushes its expected word per config (mask selects configs)
    task automatic op(input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input logic [DW/8-1:0] be, input logic r, input logic [AW-1:0] ra,
                      input logic [DW-1:0] e_rf, input logic [DW-1:0] e_wf,
                      input logic [NCFG-1:0] mask, input string nm);
        exp_t e;
        we    = w;
        waddr = wa;
        wdata = wd;
        wbe   = be;
        re    = r;
        raddr = ra;
        if (r) begin
            for (int g = 0; g < NCFG; g++) begin
                if (mask[g]) begin
                    e.data = (g % 2 == 1) ? e_wf : e_rf;
                    e.due  = cyc + 1 + g / 2;
                    e.name = nm;
                    exp_q[g].push_back(e);
                end
            end
        end
        tick();
        we  = 1'b0;
        re  = 1'b0;
        wbe = '0;
    endtask

    task automatic wr(input logic [AW-1:0] wa, input logic [DW-1:0] wd, input logic [DW/8-1:0] be);
        op(1'b1, wa, wd, be, 1'b0, 4'h0, 16'h0000, 16'h0000, 4'hF, "wr");
    endtask

    task automatic rd(input logic [AW-1:0] ra, input logic [DW-1:0] ex, input string nm);
        op(1'b0, 4'h0, 16'h0000, 2'b00, 1'b1, ra, ex, ex, 4'hF, nm);
    endtask

    task automatic drain(input string nm);
        repeat (3) tick();
        for (int g = 0; g < NCFG; g++) begin
            tests++;
            if (exp_q[g].size() != 0) begin
                fails++;
                $display("FAIL %s cfg%0d missing_rvalid: got %0d reads outstanding, required 0",
                         nm, g, exp_q[g].size());
                exp_q[g].delete();
            end
        end
    endtask

    task automatic pulse_reset(input string nm);
        rst = 1'b1;
        tick();
        check({nm, " rvalid_in_reset"}, 64'(rvalid_v), 64'h0);
        check({nm, " rdata_in_reset"}, rdata_v, 64'h0);
        check({nm, " busy_in_reset"}, 64'(busy_v), 64'hF);
        rst = 1'b0;
    endtask

    // Count busy cycles after rst falls; with hold=1 keep we/re toggling through CLEAR
    task automatic check_sweep(input logic hold, input string nm);
        int   n    = 0;
        logic done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (busy_v == 4'hF) begin
                n++;
                if (hold) begin
                    we    = 1'b1;
                    re    = 1'b1;
                    wbe   = 2'b11;
                    waddr = AW'(i);
                    raddr = AW'(i + 3);
                    wdata = 16'hBEEF;
                end
            end else begin
                done = 1'b1;
                we   = 1'b0;
                re   = 1'b0;
                wbe  = '0;
            end
        end
        check({nm, " busy_cycles"}, 64'(n), 64'd16);
        check({nm, " busy_low_all"}, 64'(busy_v), 64'h0);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at 100000, required finish earlier");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        repeat (2) tick();
        pulse_reset("por");
        check_sweep(1'b0, "por");

        for (int a = 0; a < 16; a++) rd(AW'(a), 16'h0000, "zero_after_clear");
        drain("zero_reads");

        wr(4'd3, 16'hABCD, 2'b11);
        wr(4'd3, 16'h1200, 2'b10);
        rd(4'd3, 16'h12CD, "byte_merge");
        drain("byte_merge");

        wr(4'd5, 16'h1111, 2'b11);
        op(1'b1, 4'd5, 16'h2222, 2'b11, 1'b1, 4'd5, 16'h1111, 16'h2222, 4'hF, "collision");
        rd(4'd5, 16'h2222, "after_collision");
        wr(4'd5, 16'hFFFF, 2'b00);
        rd(4'd5, 16'h2222, "wbe_zero_noop");
        op(1'b1, 4'd6, 16'h0606, 2'b11, 1'b1, 4'd5, 16'h2222, 16'h2222, 4'hF, "indep_rd");
        rd(4'd6, 16'h0606, "indep_wr");
        drain("collision");

        for (int a = 0; a < 16; a++) wr(AW'(a), 16'hC000 | 16'(a), 2'b11);
        for (int a = 0; a < 16; a++) rd(AW'(a), 16'hC000 | 16'(a), "burst");
        repeat (3) tick();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rdata_hold", rdata_v, {4{16'hC00F}});
            check("rvalid_idle", 64'(rvalid_v), 64'h0);
        end
        tick();
        drain("burst");

        op(1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'd15, 16'hC00F, 16'hC00F, 4'b0011, "pending_rd");
        pulse_reset("pending_rd");
        check_sweep(1'b0, "after_pending_rst");
        rd(4'd15, 16'h0000, "cleared_after_pending");
        drain("pending");

        pulse_reset("sweep_start");
        repeat (7) tick();
        check("busy_at_cnt7", 64'(busy_v), 64'hF);
        pulse_reset("mid_sweep");
        check_sweep(1'b0, "mid_sweep");
        drain("mid_sweep");

        wr(4'd2, 16'h5A5A, 2'b11);
        wr(4'd9, 16'hA5A5, 2'b11);
        we    = 1'b1;
        re    = 1'b1;
        wbe   = 2'b11;
        wdata = 16'hBEEF;
        pulse_reset("hold_clear");
        check_sweep(1'b1, "hold_clear");
        for (int a = 0; a < 16; a++) rd(AW'(a), 16'h0000, "zero_after_hold");
        drain("hold_clear");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
